// File: rtl/mips_fetch_pkg.sv
// ---------------------------------------------------------------------------
// mips_fetch_pkg
// Shared definitions for the instruction fetch queue:
//   - WORD_W / ADDR_W : instruction word and address widths (32 bits)
//   - PC_INC          : sequential fetch increment (one 32-bit word)
//   - fetch_state_t   : fetch FSM states (RUN issues fetches, DRAIN discards
//                       responses still in flight after a redirect)
// ---------------------------------------------------------------------------
package mips_fetch_pkg;

    localparam int WORD_W = 32;
    localparam int ADDR_W = 32;

    localparam logic [ADDR_W-1:0] PC_INC = 32'd4;

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_DRAIN = 1'b1
    } fetch_state_t;

endpackage

// File: rtl/fetch_fifo.sv
// ---------------------------------------------------------------------------
// fetch_fifo
// Synchronous FIFO with occupancy count, used both as the instruction queue
// and as the in-order address tag queue of the fetch unit.
//
// Parameters
//   WIDTH : entry width in bits
//   DEPTH : number of entries (power of two, >= 2)
// Ports
//   clk       : rising-edge clock
//   rst       : synchronous active-high reset (pointers and count cleared)
//   flush     : synchronous clear, same effect as rst, push ignored
//   push      : write push_data (ignored when full without a pop)
//   push_data : entry written on push
//   pop       : drop the head entry (ignored when empty)
//   head_data : current head entry, read straight from the storage register
//   count     : number of valid entries (0..DEPTH)
//   empty     : count == 0
//   full      : count == DEPTH
// ---------------------------------------------------------------------------
module fetch_fifo #(
    parameter  int WIDTH = 32,
    parameter  int DEPTH = 4,
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head_data,
    output logic [CNT_W-1:0] count,
    output logic             empty,
    output logic             full
);

    localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == DEPTH_CNT);
    assign do_pop  = pop && !empty;
    // A full queue still accepts a push when the head leaves in the same cycle.
    assign do_push = push && (!full || do_pop);

    // NOTE: sequential state is updated with non-blocking assignments only, so
    // every register samples the values from before this clock edge.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

    // NOTE: the storage array has no reset; an entry is only ever read after it
    // was written, and leaving it out keeps the array a plain register file.
    always_ff @(posedge clk) begin
        if (do_push && !flush && !rst) mem[wr_ptr] <= push_data;
    end

    assign head_data = mem[rd_ptr];

endmodule

// File: rtl/instr_fetch_queue.sv
// ---------------------------------------------------------------------------
// instr_fetch_queue
// Instruction fetch unit: issues sequential word fetches to instruction
// memory, pairs each in-order response with its address from a tag queue and
// buffers {pc, data} for decode. A redirect flushes the queue and restarts
// fetching at the target; responses still in flight are dropped in DRAIN.
//
// Build option: FETCH_MISALIGN_CHECK_EN adds the sticky 'misalign' output and
// stops fetching after a redirect to a non-word-aligned target. Without it
// the two low redirect target bits are forced to zero.
//
// Parameters
//   DEPTH    : queue entries (power of two, 2..16)
//   RESET_PC : first fetch address after reset
// Ports
//   clk, rst                       : clock, synchronous active-high reset
//   redirect_valid, redirect_pc    : branch/jump redirect request and target
//   imem_req_valid/ready/addr      : fetch request handshake and address
//   imem_rsp_valid, imem_rsp_data  : in-order instruction response
//   instr_valid/ready              : decode handshake on the queue head
//   instr_data, instr_pc           : head instruction word and its address
//   instr_pc_plus4                 : instr_pc + 4 (mod 2^32)
//   misalign (option only)         : sticky misaligned-redirect flag
// ---------------------------------------------------------------------------
module instr_fetch_queue
    import mips_fetch_pkg::*;
#(
    parameter int                DEPTH    = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = 32'h0000_0000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              imem_req_valid,
    input  logic              imem_req_ready,
    output logic [ADDR_W-1:0] imem_req_addr,
    input  logic              imem_rsp_valid,
    input  logic [WORD_W-1:0] imem_rsp_data,
    output logic              instr_valid,
    input  logic              instr_ready,
    output logic [WORD_W-1:0] instr_data,
    output logic [ADDR_W-1:0] instr_pc,
    output logic [ADDR_W-1:0] instr_pc_plus4
`ifdef FETCH_MISALIGN_CHECK_EN
    ,
    output logic              misalign
`endif
);

    localparam int              CNT_W     = $clog2(DEPTH) + 1;
    localparam logic [CNT_W:0]  DEPTH_EXT = (CNT_W + 1)'(DEPTH);

    fetch_state_t            state_q, state_d;
    logic [ADDR_W-1:0]        fetch_pc_q;
    logic [CNT_W-1:0]         outstanding_q;
    logic [CNT_W-1:0]         outstanding_after_rsp;
    logic [CNT_W:0]           in_flight;
    logic [ADDR_W-1:0]        redirect_target;
    logic                     misalign_q;

    logic                     req_allow;
    logic                     req_fire;
    logic                     rsp_take;
    logic                     rsp_keep;

    logic [ADDR_W+WORD_W-1:0] iq_head;
    logic [CNT_W-1:0]         iq_count;
    logic                     iq_empty;
    logic                     iq_full_unused;
    logic                     iq_pop;
    logic [ADDR_W-1:0]        tag_pc;
    logic [CNT_W-1:0]         tq_count_unused;
    logic                     tq_empty_unused;
    logic                     tq_full_unused;

`ifdef FETCH_MISALIGN_CHECK_EN
    assign redirect_target = redirect_pc;

    always_ff @(posedge clk) begin
        if (rst)                                            misalign_q <= 1'b0;
        else if (redirect_valid && (redirect_pc[1:0] != 2'b00)) misalign_q <= 1'b1;
    end

    assign misalign = misalign_q && !rst;
`else
    logic unused_pc_low;
    assign unused_pc_low   = ^redirect_pc[1:0];
    assign redirect_target = {redirect_pc[ADDR_W-1:2], 2'b00};
    assign misalign_q      = 1'b0;
`endif

    // Queue entries plus in-flight requests never exceed DEPTH, so every
    // response accepted in RUN is guaranteed a free queue slot.
    assign in_flight = {1'b0, iq_count} + {1'b0, outstanding_q};

    // Responses with nothing outstanding are stray and ignored entirely.
    assign rsp_take = imem_rsp_valid && (outstanding_q != '0);
    // A redirect suppresses requests, so the post-redirect count only sees
    // this cycle's response.
    assign outstanding_after_rsp = outstanding_q - CNT_W'(rsp_take);

    // NOTE: every variable driven here gets a default before the case, so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        state_d   = state_q;
        req_allow = 1'b0;
        rsp_keep  = 1'b0;
        case (state_q)
            ST_RUN: begin
                req_allow = !redirect_valid && !misalign_q && (in_flight < DEPTH_EXT);
                rsp_keep  = rsp_take && !redirect_valid;
                if (redirect_valid && (outstanding_after_rsp != '0)) state_d = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (outstanding_after_rsp == '0) state_d = ST_RUN;
            end
            default: state_d = ST_RUN;
        endcase
    end

    assign imem_req_valid = req_allow && !rst;
    assign imem_req_addr  = rst ? RESET_PC : fetch_pc_q;
    assign req_fire       = imem_req_valid && imem_req_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_RUN;
            fetch_pc_q    <= RESET_PC;
            outstanding_q <= '0;
        end else begin
            state_q       <= state_d;
            outstanding_q <= outstanding_q + CNT_W'(req_fire) - CNT_W'(rsp_take);
            if (redirect_valid) fetch_pc_q <= redirect_target;
            else if (req_fire)  fetch_pc_q <= fetch_pc_q + PC_INC;
        end
    end

    // Addresses of outstanding requests, consumed in order by the responses.
    fetch_fifo #(.WIDTH(ADDR_W), .DEPTH(DEPTH)) u_tag_q (
        .clk       (clk),
        .rst       (rst),
        .flush     (redirect_valid),
        .push      (req_fire),
        .push_data (fetch_pc_q),
        .pop       (rsp_take),
        .head_data (tag_pc),
        .count     (tq_count_unused),
        .empty     (tq_empty_unused),
        .full      (tq_full_unused)
    );

    // Instruction queue holding {pc, data}; its head drives the decode outputs.
    fetch_fifo #(.WIDTH(ADDR_W + WORD_W), .DEPTH(DEPTH)) u_instr_q (
        .clk       (clk),
        .rst       (rst),
        .flush     (redirect_valid),
        .push      (rsp_keep),
        .push_data ({tag_pc, imem_rsp_data}),
        .pop       (iq_pop),
        .head_data (iq_head),
        .count     (iq_count),
        .empty     (iq_empty),
        .full      (iq_full_unused)
    );

    assign instr_valid    = !iq_empty && !rst;
    assign iq_pop         = instr_valid && instr_ready;
    assign instr_data     = instr_valid ? iq_head[WORD_W-1:0] : '0;
    assign instr_pc       = instr_valid ? iq_head[ADDR_W+WORD_W-1:WORD_W] : '0;
    assign instr_pc_plus4 = instr_valid ? (iq_head[ADDR_W+WORD_W-1:WORD_W] + PC_INC) : '0;

endmodule

// File: tb/tb_instr_fetch_queue.sv
// ---------------------------------------------------------------------------
// tb_instr_fetch_queue
// Self-checking bench for instr_fetch_queue (DEPTH=4, RESET_PC=0).
// An instruction memory model answers accepted requests in order after a
// random latency; a reference model tracks the expected next fetch address
// and the expected next decoded address. Directed scenarios cover reset,
// back-pressure, redirect drain, address wrap and the redirect/pop/response
// corner; random rounds follow. The misalign scenario runs only when
// FETCH_MISALIGN_CHECK_EN is defined.
// ---------------------------------------------------------------------------
module tb_instr_fetch_queue;

    localparam int          DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr_data;
    logic [31:0] instr_pc;
    logic [31:0] instr_pc_plus4;
`ifdef FETCH_MISALIGN_CHECK_EN
    logic        misalign;
`endif

    instr_fetch_queue #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
        .clk            (clk),
        .rst            (rst),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .instr_valid    (instr_valid),
        .instr_ready    (instr_ready),
        .instr_data     (instr_data),
        .instr_pc       (instr_pc),
        .instr_pc_plus4 (instr_pc_plus4)
`ifdef FETCH_MISALIGN_CHECK_EN
        ,
        .misalign       (misalign)
`endif
    );

    always #5 clk = ~clk;

    int tests_run    = 0;
    int tests_failed = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %08h expected %08h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Memory contents: a fixed scramble of the address, never zero for addr 0.
    function automatic logic [31:0] word_of(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'hC0DE_0000;
    endfunction

    function automatic logic [31:0] log_at(input logic [31:0] q[$], input int idx);
        if (idx < q.size()) return q[idx];
        return 32'hDEAD_BEEF;
    endfunction

    typedef struct {
        logic [31:0] addr;
        int          due;
    } pend_t;

    pend_t       mem_q[$];
    logic [31:0] req_log[$];
    logic [31:0] pc_log[$];
    logic [31:0] plus4_log[$];

    int unsigned p_req_ready  = 100;
    int unsigned p_instr_ready = 100;
    int unsigned lat_min = 1;
    int unsigned lat_max = 1;

    int cyc = 0;
    int last_due = 0;
    int first_rsp_cyc = -1;
    int first_valid_cyc = -1;

    logic [31:0] m_fetch_pc;   // expected address of the next accepted request
    logic [31:0] m_exp_pc;     // expected address of the next decoded instruction

    bit obs_req_fire, obs_req_valid, obs_pop, obs_rsp, obs_instr_valid, obs_misalign;

    function automatic logic [31:0] eff_target(input logic [31:0] t);
`ifdef FETCH_MISALIGN_CHECK_EN
        return t;
`else
        return {t[31:2], 2'b00};
`endif
    endfunction

    task automatic cycle(input bit do_redirect, input logic [31:0] target);
        int due;
        @(negedge clk);
        cyc++;
        imem_req_ready = ($urandom_range(99, 0) < p_req_ready);
        instr_ready    = ($urandom_range(99, 0) < p_instr_ready);
        redirect_valid = do_redirect;
        redirect_pc    = target;
        if (mem_q.size() > 0 && mem_q[0].due <= cyc) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = word_of(mem_q[0].addr);
            void'(mem_q.pop_front());
            obs_rsp = 1'b1;
        end else begin
            imem_rsp_valid = 1'b0;
            imem_rsp_data  = $urandom;
            obs_rsp = 1'b0;
        end
        #1;
        obs_req_valid   = imem_req_valid;
        obs_req_fire    = imem_req_valid && imem_req_ready;
        obs_instr_valid = instr_valid;
        obs_pop         = instr_valid && instr_ready;
`ifdef FETCH_MISALIGN_CHECK_EN
        obs_misalign    = misalign;
`else
        obs_misalign    = 1'b0;
`endif
        if (obs_rsp && first_rsp_cyc < 0) first_rsp_cyc = cyc;
        if (obs_instr_valid && first_valid_cyc < 0) first_valid_cyc = cyc;

        if (obs_req_fire) begin
            check("req_addr", imem_req_addr, m_fetch_pc);
            req_log.push_back(imem_req_addr);
            m_fetch_pc += 32'd4;
            due = cyc + int'($urandom_range(lat_max, lat_min));
            if (due <= last_due) due = last_due + 1;
            last_due = due;
            mem_q.push_back('{addr: imem_req_addr, due: due});
        end
        if (obs_pop) begin
            check("pop_pc", instr_pc, m_exp_pc);
            check("pop_data", instr_data, word_of(m_exp_pc));
            check("pop_pc_plus4", instr_pc_plus4, m_exp_pc + 32'd4);
            pc_log.push_back(instr_pc);
            plus4_log.push_back(instr_pc_plus4);
            m_exp_pc += 32'd4;
        end
        if (do_redirect) begin
            check("redirect_req_suppressed", 32'(obs_req_valid), 32'd0);
            m_fetch_pc = eff_target(target);
            m_exp_pc   = eff_target(target);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = '0;
        instr_ready    = 1'b0;
        @(negedge clk);
        #1;
        check("rst_req_valid", 32'(imem_req_valid), 32'd0);
        check("rst_req_addr", imem_req_addr, RESET_PC);
        check("rst_instr_valid", 32'(instr_valid), 32'd0);
        check("rst_instr_data", instr_data, 32'd0);
        check("rst_instr_pc", instr_pc, 32'd0);
        check("rst_instr_pc_plus4", instr_pc_plus4, 32'd0);
`ifdef FETCH_MISALIGN_CHECK_EN
        check("rst_misalign", 32'(misalign), 32'd0);
`endif
        @(negedge clk);
        rst = 1'b0;
        mem_q.delete();
        req_log.delete();
        pc_log.delete();
        plus4_log.delete();
        m_fetch_pc      = RESET_PC;
        m_exp_pc        = RESET_PC;
        last_due        = cyc;
        first_rsp_cyc   = -1;
        first_valid_cyc = -1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int rsp_cnt;
        rst = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = '0;
        instr_ready    = 1'b0;

        // Streaming fetch: ready memory, 1-cycle latency, decode always ready.
        do_reset();
        p_req_ready = 100; p_instr_ready = 100; lat_min = 1; lat_max = 1;
        for (int i = 0; i < 20; i++) cycle(1'b0, '0);
        check("t1_first_req", log_at(req_log, 0), 32'h0);
        check("t1_third_req", log_at(req_log, 2), 32'h8);
        check("t1_delivered", 32'(pc_log.size() >= 10), 32'd1);
        check("t1_rsp_to_valid", 32'(first_valid_cyc - first_rsp_cyc), 32'd1);

        // Decode stalled: exactly DEPTH requests, then resume at 0x10.
        do_reset();
        p_req_ready = 100; p_instr_ready = 0;
        for (int i = 0; i < 10; i++) cycle(1'b0, '0);
        check("t2_req_count", 32'(req_log.size()), 32'd4);
        check("t2_req_valid_low", 32'(obs_req_valid), 32'd0);
        p_instr_ready = 100;
        for (int i = 0; i < 10 && req_log.size() < 5; i++) cycle(1'b0, '0);
        check("t2_resume_addr", log_at(req_log, 4), 32'h10);

        // Redirect with two requests outstanding: drain, then restart at 0x100.
        do_reset();
        p_req_ready = 100; p_instr_ready = 0; lat_min = 4; lat_max = 4;
        cycle(1'b0, '0);
        cycle(1'b0, '0);
        check("t3_outstanding", 32'(req_log.size()), 32'd2);
        p_req_ready = 0;
        cycle(1'b1, 32'h100);
        p_req_ready = 100;
        rsp_cnt = 0;
        for (int i = 0; i < 3; i++) begin
            cycle(1'b0, '0);
            check("t3_drain_no_req", 32'(obs_req_valid), 32'd0);
            if (obs_rsp) rsp_cnt++;
        end
        check("t3_dropped_rsp", 32'(rsp_cnt), 32'd2);
        cycle(1'b0, '0);
        check("t3_req_after_drain", 32'(obs_req_fire), 32'd1);
        check("t3_req_addr", log_at(req_log, 2), 32'h100);
        p_instr_ready = 100; lat_min = 1; lat_max = 1;
        for (int i = 0; i < 20 && pc_log.size() == 0; i++) cycle(1'b0, '0);
        check("t3_first_pc", log_at(pc_log, 0), 32'h100);
        check("t3_no_stale_instr", 32'(obs_instr_valid || pc_log.size() > 0), 32'd1);

        // Address wrap at the top of the 32-bit space.
        do_reset();
        p_req_ready = 100; p_instr_ready = 100;
        cycle(1'b1, 32'hFFFF_FFF8);
        for (int i = 0; i < 12; i++) cycle(1'b0, '0);
        check("t4_req_top", log_at(req_log, 1), 32'hFFFF_FFFC);
        check("t4_req_wrap", log_at(req_log, 2), 32'h0);
        check("t4_pc_top", log_at(pc_log, 1), 32'hFFFF_FFFC);
        check("t4_plus4_wrap", log_at(plus4_log, 1), 32'h0);

        // Redirect, pop and response all in one cycle.
        do_reset();
        p_req_ready = 100; p_instr_ready = 0;
        cycle(1'b0, '0);
        cycle(1'b0, '0);
        p_instr_ready = 100;
        cycle(1'b1, 32'h200);
        check("t5_pop_in_redirect", 32'(obs_pop), 32'd1);
        check("t5_rsp_in_redirect", 32'(obs_rsp), 32'd1);
        p_req_ready = 0;
        cycle(1'b0, '0);
        check("t5_queue_empty", 32'(obs_instr_valid), 32'd0);
        check("t5_delivered_once", 32'(pc_log.size()), 32'd1);
        check("t5_popped_pc", log_at(pc_log, 0), 32'h0);
        p_req_ready = 100;
        for (int i = 0; i < 10 && pc_log.size() < 2; i++) cycle(1'b0, '0);
        check("t5_next_pc", log_at(pc_log, 1), 32'h200);

`ifdef FETCH_MISALIGN_CHECK_EN
        // Misaligned redirect: sticky flag, fetching stops until reset.
        do_reset();
        p_req_ready = 100; p_instr_ready = 100;
        cycle(1'b1, 32'h102);
        cycle(1'b0, '0);
        check("t6_misalign_set", 32'(obs_misalign), 32'd1);
        for (int i = 0; i < 10; i++) cycle(1'b0, '0);
        check("t6_no_requests", 32'(req_log.size()), 32'd0);
        check("t6_misalign_sticky", 32'(obs_misalign), 32'd1);
        do_reset();
        for (int i = 0; i < 5; i++) cycle(1'b0, '0);
        check("t6_misalign_cleared", 32'(obs_misalign), 32'd0);
        check("t6_fetch_resumed", 32'(req_log.size() > 0), 32'd1);
`endif

        // Random traffic; each round starts with a reset while traffic is live.
        for (int r = 0; r < 4; r++) begin
            do_reset();
            for (int i = 0; i < 400; i++) begin
                logic [31:0] tgt;
                if (i % 50 == 0) begin
                    p_req_ready   = $urandom_range(100, 30);
                    p_instr_ready = $urandom_range(100, 30);
                    lat_min       = 1;
                    lat_max       = $urandom_range(4, 1);
                end
                tgt = ($urandom_range(3, 0) == 0) ? (32'hFFFF_FFF0 | ($urandom & 32'hC)) : $urandom;
`ifdef FETCH_MISALIGN_CHECK_EN
                tgt[1:0] = 2'b00;
`endif
                cycle($urandom_range(99, 0) < 3, tgt);
            end
            check("rand_progress", 32'(pc_log.size() > 0), 32'd1);
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
